ad9958_write_sequencer: RTL and testbench
=========================================

// Module: ad9958_write_sequencer
// PURPOSE
//  Sequences register writes to the AD9958 DDS through the four_bit_spi serializer. After reset it
//  pulses the DDS master reset, writes CSR in 1-bit SPI mode to select 4-bit serial, then switches four_bit.
//  Afterwards it accepts {addr,data} write requests, frames instruction byte + data at the per-register
//  width, runs one SPI transaction per request and pulses IO_UPDATE on request. It sits between host logic and four_bit_spi.
// PARAMETERS
//  INIT_CSR        8'hF6  CSR value written at init (all channels enabled, CSR[2:1]=2'b11 selects 4-bit serial)
//  MR_CYCLES       8      dds_master_reset high time, clock cycles
//  IOUPD_CYCLES    4      io_update high time, clock cycles
//  BUSY_TIMEOUT    16     max cycles from trigger assertion to spi_busy=1
// PORTS
//  clock            in   1   system clock, all logic on rising edge
//  reset            in   1   synchronous, active-high
//  req_valid        in   1   write request valid
//  req_ready        out  1   sequencer can accept a request (IDLE only)
//  req_addr         in   5   AD9958 register address, 0x00..0x18 legal
//  req_data         in   32  register value, right-aligned (LSBs used for registers narrower than 4 bytes)
//  req_update       in   1   pulse io_update after this write completes
//  init_done        out  1   high once 4-bit mode is established; stays high until reset
//  err_addr         out  1   1-cycle pulse: request with address >0x18 accepted and dropped
//  err_timeout      out  1   sticky: spi_busy never rose within BUSY_TIMEOUT; cleared only by reset
//  spi_trigger      out  1   to four_bit_spi.trigger
//  spi_four_bit     out  1   to four_bit_spi.four_bit
//  spi_bits_to_send out  6   to four_bit_spi.bits_to_send
//  spi_data_input   out  64  to four_bit_spi.data_input; frame right-aligned, bit [bits_to_send-1] shifted first
//  spi_busy         in   1   from four_bit_spi.busy
//  dds_master_reset out  1   to AD9958 MASTER_RESET pin
//  io_update        out  1   to AD9958 IO_UPDATE pin
// BEHAVIOUR
//  Reset values: req_ready=0, init_done=0, err_*=0, spi_trigger=0, spi_four_bit=0, spi_bits_to_send=0,
//   spi_data_input=0, dds_master_reset=0, io_update=0; FSM to MR.
//  Frame: instr = {1'b0 (write), 2'b00, addr[4:0]}; nbytes from addr table: 0x00:1, 0x01:3, 0x02:2, 0x03:3,
//   0x04:4, 0x05:2, 0x06:3, 0x07:2, 0x08-0x18:4. bits_to_send = 8+8*nbytes (16..40);
//   spi_data_input = {instr, data[8*nbytes-1:0]} zero-extended to 64. spi_data_input/bits/four_bit are
//   held stable from LOAD until the transaction returns to IDLE.
//  FSM: MR (dds_master_reset=1, MR_CYCLES) -> INIT_LOAD (frame CSR=INIT_CSR, four_bit=0) -> TRIG ->
//   WAIT_DONE -> INIT_SET (spi_four_bit<=1, init_done<=1) -> IDLE.
//   IDLE: req_ready=1; on req_valid&&req_ready capture addr/data/update -> LOAD (illegal addr: err_addr pulse, stay IDLE).
//   LOAD: drive frame (1 cycle) -> TRIG. TRIG: spi_trigger=1 held until spi_busy=1 sampled, then 0 -> WAIT_DONE.
//   WAIT_DONE: wait spi_busy=0 -> UPDATE if captured update else IDLE. UPDATE: io_update=1 IOUPD_CYCLES -> IDLE.
//  Latency: accept -> spi_trigger high = 2 cycles. Back-to-back: next req_ready one cycle after WAIT_DONE/UPDATE exit.
//  Timeout: TRIG >BUSY_TIMEOUT cycles -> spi_trigger=0, err_timeout=1, FSM to IDLE (request dropped).
//  CSR write after init (addr 0x00) is permitted; sequencer keeps four_bit=1 — host must keep CSR[2:1]=2'b11.
//  Reset mid-transaction: outputs take reset values next edge; whole init sequence (incl. master reset) reruns,
//   which returns the DDS to 1-bit mode consistently with spi_four_bit=0.
//  spi_busy high while in IDLE is ignored. req_valid during non-IDLE is not accepted (req_ready=0).
// STRUCTURE
//  Package ad9958_pkg: register address localparams (CSR..CW15), reg_nbytes(addr) function, instr byte
//   layout constants, FSM state encoding. One sub-module: ad9958_frame_builder (combinational addr/data ->
//   bits_to_send, data_input); FSM, timers and pulses in this module.
// TESTING (bench instantiates four_bit_spi as the slave plus an AD9958 pin monitor)
//  1 reset 5 cycles -> master reset high 8 cycles; 1-bit frame 0x00F6, bits=16; then init_done=1, four_bit=1.
//  2 req addr=0x04 data=0x12345678 update=1 -> bits=40, data_input=0x0412345678, 4-bit on sdio; io_update 4 cycles.
//  3 req addr=0x05 data=0xFFFF3FFF -> bits=24, data_input=0x053FFF; no io_update.
//  4 req addr=0x1F -> err_addr 1-cycle pulse, no spi_trigger, req_ready stays 1.
//  5 spi_busy tied 0 -> err_timeout set after 16 trigger cycles; subsequent req still accepted.
//  6 reset asserted mid WAIT_DONE -> all outputs at reset values next cycle; init sequence repeats exactly.

Source files
------------

// File: rtl/ad9958_pkg.sv
// ad9958_pkg: AD9958 register map, instruction byte layout, register widths and sequencer states
package ad9958_pkg;
  localparam logic [4:0] ADDR_CSR   = 5'h00;
  localparam logic [4:0] ADDR_FR1   = 5'h01;
  localparam logic [4:0] ADDR_FR2   = 5'h02;
  localparam logic [4:0] ADDR_CFR   = 5'h03;
  localparam logic [4:0] ADDR_CFTW0 = 5'h04;
  localparam logic [4:0] ADDR_CPOW0 = 5'h05;
  localparam logic [4:0] ADDR_ACR   = 5'h06;
  localparam logic [4:0] ADDR_LSRR  = 5'h07;
  localparam logic [4:0] ADDR_CW15  = 5'h18;
  localparam logic       INSTR_WRITE = 1'b0;
  localparam logic [1:0] INSTR_PAD   = 2'b00;
  typedef enum logic [2:0] {
    ST_MR, ST_INIT_LOAD, ST_TRIG, ST_WAIT_DONE, ST_INIT_SET, ST_IDLE, ST_LOAD, ST_UPDATE
  } state_t;
  function automatic logic [2:0] reg_nbytes(input logic [4:0] addr);
    return addr == ADDR_CSR ? 3'd1 :
           (addr == ADDR_FR1 || addr == ADDR_CFR || addr == ADDR_ACR) ? 3'd3 :
           (addr == ADDR_FR2 || addr == ADDR_CPOW0 || addr == ADDR_LSRR) ? 3'd2 : 3'd4;
  endfunction
  function automatic logic addr_legal(input logic [4:0] addr);
    return addr <= ADDR_CW15;
  endfunction
endpackage

// File: rtl/ad9958_frame_builder.sv
// ad9958_frame_builder: builds the right-aligned {instr, data} SPI frame and its bit count for one register write
module ad9958_frame_builder
  import ad9958_pkg::*;
(
  input  logic [4:0]  addr,
  input  logic [31:0] data,
  output logic [5:0]  bits_to_send,
  output logic [63:0] data_input
);
  logic [5:0] data_bits;
  logic [7:0] instr;
  always_comb begin
    data_bits = {reg_nbytes(addr), 3'b000};
    instr = {INSTR_WRITE, INSTR_PAD, addr};
    bits_to_send = data_bits + 6'd8;
    data_input = (64'(instr) << data_bits) | (64'(data) & ((64'd1 << data_bits) - 64'd1));
  end
endmodule

// File: rtl/ad9958_write_sequencer.sv
// ad9958_write_sequencer: AD9958 init (master reset, CSR to 4-bit mode) then host register writes via four_bit_spi
module ad9958_write_sequencer
  import ad9958_pkg::*;
#(
  parameter logic [7:0] INIT_CSR     = 8'hF6,
  parameter int         MR_CYCLES    = 8,
  parameter int         IOUPD_CYCLES = 4,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  input  logic        req_update,
  output logic        init_done,
  output logic        err_addr,
  output logic        err_timeout,
  output logic        spi_trigger,
  output logic        spi_four_bit,
  output logic [5:0]  spi_bits_to_send,
  output logic [63:0] spi_data_input,
  input  logic        spi_busy,
  output logic        dds_master_reset,
  output logic        io_update
);
  state_t state, next;
  logic [7:0] cnt;
  logic [4:0] cap_addr;
  logic [31:0] cap_data;
  logic cap_update, accept, timeout, init_frame;
  logic ready_d, trig_d, mr_d, iou_d, err_addr_d;
  logic [5:0] fb_bits;
  logic [63:0] fb_data;
  assign init_frame = state == ST_INIT_LOAD;
  ad9958_frame_builder u_frame (
    .addr(init_frame ? ADDR_CSR : cap_addr),
    .data(init_frame ? 32'(INIT_CSR) : cap_data),
    .bits_to_send(fb_bits),
    .data_input(fb_data)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_MR;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : cnt + 8'd1;
    end
  end
  always_comb begin
    accept = state == ST_IDLE && req_valid;
    timeout = state == ST_TRIG && !spi_busy && cnt == 8'(BUSY_TIMEOUT - 1);
    next = state;
    case (state)
      ST_MR:                  next = cnt == 8'(MR_CYCLES) ? ST_INIT_LOAD : ST_MR;
      ST_INIT_LOAD, ST_LOAD:  next = ST_TRIG;
      ST_TRIG:                next = spi_busy ? ST_WAIT_DONE : timeout ? ST_IDLE : ST_TRIG;
      ST_WAIT_DONE:           next = spi_busy ? ST_WAIT_DONE : !init_done ? ST_INIT_SET :
                                     cap_update ? ST_UPDATE : ST_IDLE;
      ST_INIT_SET:            next = ST_IDLE;
      ST_IDLE:                next = accept && addr_legal(req_addr) ? ST_LOAD : ST_IDLE;
      ST_UPDATE:              next = cnt == 8'(IOUPD_CYCLES - 1) ? ST_IDLE : ST_UPDATE;
      default:                next = ST_MR;
    endcase
  end
  always_comb begin
    ready_d = next == ST_IDLE;
    trig_d = next == ST_TRIG;
    mr_d = next == ST_MR;
    iou_d = next == ST_UPDATE;
    err_addr_d = accept && !addr_legal(req_addr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready <= 1'b0;
      spi_trigger <= 1'b0;
      dds_master_reset <= 1'b0;
      io_update <= 1'b0;
      err_addr <= 1'b0;
      err_timeout <= 1'b0;
      init_done <= 1'b0;
      spi_four_bit <= 1'b0;
      spi_bits_to_send <= '0;
      spi_data_input <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_update <= 1'b0;
    end else begin
      req_ready <= ready_d;
      spi_trigger <= trig_d;
      dds_master_reset <= mr_d;
      io_update <= iou_d;
      err_addr <= err_addr_d;
      err_timeout <= err_timeout | timeout;
      if (accept) begin
        cap_addr <= req_addr;
        cap_data <= req_data;
        cap_update <= req_update;
      end
      if (state == ST_INIT_LOAD || state == ST_LOAD) begin
        spi_bits_to_send <= fb_bits;
        spi_data_input <= fb_data;
      end
      if (state == ST_INIT_SET) begin
        spi_four_bit <= 1'b1;
        init_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ad9958_write_sequencer.sv
// tb_ad9958_write_sequencer: directed checks of init, framing, io_update, address error, timeout and reset recovery
module tb_ad9958_write_sequencer;
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, req_update = 1'b0, spi_busy = 1'b0;
  logic [4:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic req_ready, init_done, err_addr, err_timeout, spi_trigger, spi_four_bit, dds_master_reset, io_update;
  logic [5:0] spi_bits_to_send;
  logic [63:0] spi_data_input;
  logic slave_en = 1'b1;
  int errors = 0, checks = 0;
  int sl_cnt = 0, n_trans = 0, mr_cyc = 0, iou_cyc = 0, trig_cyc = 0;
  logic [63:0] last_data = '0;
  logic [5:0] last_bits = '0;
  logic last_fb = 1'b0;
  always #5 clock = ~clock;
  ad9958_write_sequencer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_update(req_update),
    .init_done(init_done), .err_addr(err_addr), .err_timeout(err_timeout),
    .spi_trigger(spi_trigger), .spi_four_bit(spi_four_bit), .spi_bits_to_send(spi_bits_to_send),
    .spi_data_input(spi_data_input), .spi_busy(spi_busy),
    .dds_master_reset(dds_master_reset), .io_update(io_update)
  );
  always @(posedge clock) begin
    if (dds_master_reset) mr_cyc <= mr_cyc + 1;
    if (io_update) iou_cyc <= iou_cyc + 1;
    if (spi_trigger) trig_cyc <= trig_cyc + 1;
    if (reset) begin
      spi_busy <= 1'b0;
      sl_cnt <= 0;
    end else if (!spi_busy && spi_trigger && slave_en) begin
      spi_busy <= 1'b1;
      sl_cnt <= spi_four_bit ? int'(spi_bits_to_send) / 4 : int'(spi_bits_to_send);
      last_data <= spi_data_input;
      last_bits <= spi_bits_to_send;
      last_fb <= spi_four_bit;
      n_trans <= n_trans + 1;
    end else if (spi_busy) begin
      sl_cnt <= sl_cnt - 1;
      if (sl_cnt == 1) spi_busy <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [4:0] a, input logic [31:0] d, input logic u);
    req_addr = a;
    req_data = d;
    req_update = u;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int i = 0;
    while (!req_ready && i < 300) begin
      @(negedge clock);
      i++;
    end
    chk(tag, 64'(req_ready), 64'd1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk(tag, {spi_data_input, 2'b00, spi_bits_to_send, req_ready, init_done, err_addr, err_timeout,
              spi_trigger, spi_four_bit, dds_master_reset, io_update}, '0);
  endtask
  task automatic chk_init(input string tag);
    int m0 = mr_cyc, n0 = n_trans, i = 0;
    while (!init_done && i < 300) begin
      @(negedge clock);
      i++;
    end
    chk({tag, "_done"}, 64'(init_done), 64'd1);
    chk({tag, "_mr_cycles"}, 64'(mr_cyc - m0), 64'd8);
    chk({tag, "_trans"}, 64'(n_trans - n0), 64'd1);
    chk({tag, "_frame"}, last_data, 64'h00F6);
    chk({tag, "_bits"}, 64'(last_bits), 64'd16);
    chk({tag, "_frame_1bit"}, 64'(last_fb), 64'd0);
    chk({tag, "_four_bit"}, 64'(spi_four_bit), 64'd1);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask
  initial begin
    int t0, n0, i;
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, n0, i;
    repeat (5) @(negedge clock);
    chk_reset_outputs("reset_values");
    reset = 1'b0;
    chk_init("init");
    t0 = iou_cyc;
    n0 = n_trans;
    send(5'h04, 32'h12345678, 1'b1);
    chk("t2_ready_low", 64'(req_ready), 64'd0);
    chk("t2_trig_early", 64'(spi_trigger), 64'd0);
    @(negedge clock);
    chk("t2_trig_latency", 64'(spi_trigger), 64'd1);
    chk("t2_bits", 64'(spi_bits_to_send), 64'd40);
    chk("t2_data", spi_data_input, 64'h0412345678);
    wait_ready("t2_ready");
    chk("t2_slave_data", last_data, 64'h0412345678);
    chk("t2_slave_4bit", 64'(last_fb), 64'd1);
    chk("t2_trans", 64'(n_trans - n0), 64'd1);
    chk("t2_ioupdate", 64'(iou_cyc - t0), 64'd4);
    t0 = iou_cyc;
    send(5'h05, 32'hFFFF3FFF, 1'b0);
    wait_ready("t3_ready");
    chk("t3_bits", 64'(last_bits), 64'd24);
    chk("t3_data", last_data, 64'h053FFF);
    chk("t3_no_ioupdate", 64'(iou_cyc - t0), 64'd0);
    t0 = trig_cyc;
    n0 = n_trans;
    send(5'h1F, 32'hDEADBEEF, 1'b1);
    chk("t4_err_addr", 64'(err_addr), 64'd1);
    chk("t4_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    chk("t4_err_pulse_end", 64'(err_addr), 64'd0);
    repeat (3) @(negedge clock);
    chk("t4_no_trigger", 64'(trig_cyc - t0), 64'd0);
    chk("t4_no_trans", 64'(n_trans - n0), 64'd0);
    slave_en = 1'b0;
    t0 = trig_cyc;
    send(5'h08, 32'h0000000A, 1'b0);
    i = 0;
    while (!err_timeout && i < 100) begin
      @(negedge clock);
      i++;
    end
    chk("t5_err_timeout", 64'(err_timeout), 64'd1);
    chk("t5_trig_cycles", 64'(trig_cyc - t0), 64'd16);
    chk("t5_trig_low", 64'(spi_trigger), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd1);
    slave_en = 1'b1;
    send(5'h01, 32'h00ABCDEF, 1'b0);
    wait_ready("t5_fr1_ready");
    chk("t5_fr1_bits", 64'(last_bits), 64'd32);
    chk("t5_fr1_data", last_data, 64'h01ABCDEF);
    send(5'h02, 32'h1234BEEF, 1'b0);
    wait_ready("t5_fr2_ready");
    chk("t5_fr2_data", last_data, 64'h02BEEF);
    send(5'h00, 32'h000000F6, 1'b0);
    wait_ready("t5_csr_ready");
    chk("t5_csr_data", last_data, 64'h00F6);
    chk("t5_csr_4bit", 64'(last_fb), 64'd1);
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);
    send(5'h18, 32'hCAFEF00D, 1'b1);
    i = 0;
    while (!(spi_busy && !spi_trigger) && i < 50) begin
      @(negedge clock);
      i++;
    end
    chk("t6_in_wait_done", 64'(spi_busy && !spi_trigger), 64'd1);
    chk("t6_data", spi_data_input, 64'h18CAFEF00D);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("t6_reset_values");
    reset = 1'b0;
    chk_init("t6_reinit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
